// File: rtl/pe_mac_tile_pkg.sv
// Shared FP32 definitions and arithmetic cores for the systolic-array MAC tile.
// The multiplier/adder round to nearest-even, flush subnormals to zero and pass NaN/Inf through.
package pe_mac_tile_pkg;

  localparam int FP_W     = 32;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic {
    RB_EMPTY = 1'b0,
    RB_FULL  = 1'b1
  } rb_state_e;

  function automatic logic [FP_EXP_W-1:0] fp_exp(input logic [FP_W-1:0] x);
    return x[FP_W-2 -: FP_EXP_W];
  endfunction

  function automatic logic [FP_MAN_W-1:0] fp_man(input logic [FP_W-1:0] x);
    return x[FP_MAN_W-1:0];
  endfunction

  function automatic logic fp_is_zero(input logic [FP_W-1:0] x);
    return x[FP_W-2:0] == 31'd0;
  endfunction

  function automatic logic fp_is_nan(input logic [FP_W-1:0] x);
    return (fp_exp(x) == 8'hFF) && (fp_man(x) != 23'd0);
  endfunction

  function automatic logic fp_is_inf(input logic [FP_W-1:0] x);
    return (fp_exp(x) == 8'hFF) && (fp_man(x) == 23'd0);
  endfunction

  // mant carries the hidden one in bit 23; g/st are the guard and sticky bits below it.
  function automatic logic [FP_W-1:0] fp_round(input logic s, input logic signed [9:0] e,
                                               input logic [23:0] mant, input logic g,
                                               input logic st);
    logic [24:0]       r;
    logic signed [9:0] er;
    r  = {1'b0, mant} + {24'd0, g & (st | mant[0])};
    er = e;
    if (r[24]) begin
      r  = {1'b0, r[24:1]};
      er = er + 10'sd1;
    end
    if (er >= 10'sd255) return {s, 8'hFF, 23'd0};
    if (er <= 10'sd0)   return {s, 31'd0};
    return {s, er[7:0], r[22:0]};
  endfunction

  function automatic logic [FP_W-1:0] fp_mul(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    logic              s;
    logic [47:0]       p;
    logic signed [9:0] e;
    s = a[31] ^ b[31];
    if (fp_is_nan(a)) return a;
    if (fp_is_nan(b)) return b;
    if (fp_is_inf(a) || fp_is_inf(b))
      return (fp_exp(a) == 8'd0 || fp_exp(b) == 8'd0) ? FP_QNAN : {s, 8'hFF, 23'd0};
    if (fp_exp(a) == 8'd0 || fp_exp(b) == 8'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, fp_man(a)} * {24'd0, 1'b1, fp_man(b)};
    e = $signed({2'b00, fp_exp(a)}) + $signed({2'b00, fp_exp(b)}) - 10'sd127;
    if (p[47]) return fp_round(s, e + 10'sd1, p[47:24], p[23], |p[22:0]);
    return fp_round(s, e, p[46:23], p[22], |p[21:0]);
  endfunction

  function automatic logic [FP_W-1:0] fp_add(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    logic [FP_W-1:0]   x, y;
    logic [7:0]        d;
    logic [26:0]       mx, my;
    logic [27:0]       sm;
    logic signed [9:0] e;
    if (fp_is_nan(a)) return a;
    if (fp_is_nan(b)) return b;
    if (fp_is_inf(a) && fp_is_inf(b) && (a[31] != b[31])) return FP_QNAN;
    if (fp_is_inf(a)) return a;
    if (fp_is_inf(b)) return b;
    if (fp_exp(a) == 8'd0) return (fp_exp(b) == 8'd0) ? {a[31] & b[31], 31'd0} : b;
    if (fp_exp(b) == 8'd0) return a;
    if (a[30:0] >= b[30:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    d  = fp_exp(x) - fp_exp(y);
    mx = {1'b1, fp_man(x), 3'b000};
    my = {1'b1, fp_man(y), 3'b000};
    // Alignment keeps every shifted-out bit ORed into the sticky LSB.
    if (d >= 8'd27) my = 27'd1;
    else
      for (int i = 0; i < 27; i++)
        if (i < int'(d)) my = {1'b0, my[26:2], my[1] | my[0]};
    sm = (x[31] ^ y[31]) ? ({1'b0, mx} - {1'b0, my}) : ({1'b0, mx} + {1'b0, my});
    if (sm == 28'd0) return FP_ZERO;
    e = $signed({2'b00, fp_exp(x)});
    if (sm[27]) begin
      sm = {1'b0, sm[27:2], sm[1] | sm[0]};
      e  = e + 10'sd1;
    end else begin
      for (int i = 0; i < 26; i++)
        if (!sm[26]) begin
          sm = {sm[26:0], 1'b0};
          e  = e - 10'sd1;
        end
    end
    return fp_round(x[31], e, sm[26:3], sm[2], |sm[1:0]);
  endfunction

endpackage

// File: rtl/pe_res_buf.sv
// Result holding register with ready/valid, sticky overflow flag and an optional skid stage.
module pe_res_buf
  import pe_mac_tile_pkg::*;
#(
  parameter int PIPE_OUT = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [FP_W-1:0]  in_res,
  input  logic [CNT_W-1:0] in_cnt,
  output logic [FP_W-1:0]  res_o,
  output logic [CNT_W-1:0] res_cnt_o,
  output logic             res_vld_o,
  input  logic             res_rdy_i,
  output logic             ovf_o
);

  rb_state_e        state, state_nxt;
  logic [FP_W-1:0]  hold_res;
  logic [CNT_W-1:0] hold_cnt;
  logic             hold_take;
  logic             hold_load;
  logic             ovf_set;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    hold_load = 1'b0;
    ovf_set   = 1'b0;
    case (state)
      RB_EMPTY: begin
        if (in_vld) begin
          state_nxt = RB_FULL;
          hold_load = 1'b1;
        end
      end
      RB_FULL: begin
        if (hold_take) begin
          hold_load = in_vld;
          state_nxt = in_vld ? RB_FULL : RB_EMPTY;
        end else if (in_vld) begin
          ovf_set = 1'b1;
        end
      end
      default: state_nxt = RB_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RB_EMPTY;
      hold_res <= FP_ZERO;
      hold_cnt <= '0;
      ovf_o    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hold_load) begin
        hold_res <= in_res;
        hold_cnt <= in_cnt;
      end
      if (ovf_set) ovf_o <= 1'b1;
    end
  end

  generate
    if (PIPE_OUT != 0) begin : g_skid
      // The holding register becomes the skid entry behind the output register.
      logic             out_vld;
      logic [FP_W-1:0]  out_res;
      logic [CNT_W-1:0] out_cnt;
      logic             out_free;

      assign out_free  = ~out_vld | res_rdy_i;
      assign hold_take = out_free;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_vld <= 1'b0;
          out_res <= FP_ZERO;
          out_cnt <= '0;
        end else if (out_free) begin
          out_vld <= (state == RB_FULL);
          if (state == RB_FULL) begin
            out_res <= hold_res;
            out_cnt <= hold_cnt;
          end
        end
      end

      assign res_o     = out_res;
      assign res_cnt_o = out_cnt;
      assign res_vld_o = out_vld;
    end else begin : g_direct
      assign hold_take = res_rdy_i;
      assign res_o     = hold_res;
      assign res_cnt_o = hold_cnt;
      assign res_vld_o = (state == RB_FULL);
    end
  endgenerate

endmodule

// File: rtl/pe_mac_tile.sv
// FP32 output-stationary systolic PE: forwards operands, multiplies valid pairs and
// accumulates per tile, restarting on the "last" product without a bubble.
module pe_mac_tile
  import pe_mac_tile_pkg::*;
#(
  parameter int PIPE_OUT  = 0,
  parameter int ZERO_SKIP = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [FP_W-1:0]  top_i,
  input  logic             top_vld_i,
  input  logic [FP_W-1:0]  left_i,
  input  logic             left_vld_i,
  input  logic             left_last_i,
  output logic [FP_W-1:0]  bottom_o,
  output logic             bottom_vld_o,
  output logic [FP_W-1:0]  right_o,
  output logic             right_vld_o,
  output logic             right_last_o,
  output logic [FP_W-1:0]  res_o,
  output logic [CNT_W-1:0] res_cnt_o,
  output logic             res_vld_o,
  input  logic             res_rdy_i,
  output logic             ovf_o
);

  logic [FP_W-1:0]  top_s1, left_s1;
  logic             top_vld_s1, left_vld_s1, last_s1;
  logic             mac_v;
  logic [FP_W-1:0]  prod_d, prod;
  logic             prod_vld, prod_last;
  logic [FP_W-1:0]  acc, sum;
  logic [CNT_W-1:0] cnt, cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      top_s1      <= FP_ZERO;
      left_s1     <= FP_ZERO;
      top_vld_s1  <= 1'b0;
      left_vld_s1 <= 1'b0;
      last_s1     <= 1'b0;
    end else begin
      top_s1      <= top_i;
      left_s1     <= left_i;
      top_vld_s1  <= top_vld_i;
      left_vld_s1 <= left_vld_i;
      last_s1     <= left_last_i;
    end
  end

  assign bottom_o     = top_s1;
  assign bottom_vld_o = top_vld_s1;
  assign right_o      = left_s1;
  assign right_vld_o  = left_vld_s1;
  assign right_last_o = last_s1;

  assign mac_v = top_vld_s1 & left_vld_s1;

  always_comb begin
    prod_d = fp_mul(top_s1, left_s1);
    if ((ZERO_SKIP != 0) && (fp_is_zero(top_s1) || fp_is_zero(left_s1))) prod_d = FP_ZERO;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod      <= FP_ZERO;
      prod_vld  <= 1'b0;
      prod_last <= 1'b0;
    end else begin
      prod      <= prod_d;
      prod_vld  <= mac_v;
      prod_last <= mac_v & last_s1;
    end
  end

  always_comb begin
    sum = fp_add(acc, prod);
    if (ZERO_SKIP != 0) begin
      if (fp_is_zero(acc))       sum = prod;
      else if (fp_is_zero(prod)) sum = acc;
    end
    if (fp_is_zero(sum)) sum = FP_ZERO;
  end

  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

  // A last product retires the sum to the result buffer and clears the accumulator in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= FP_ZERO;
      cnt <= '0;
    end else if (prod_vld) begin
      acc <= prod_last ? FP_ZERO : sum;
      cnt <= prod_last ? '0 : cnt_inc;
    end
  end

  pe_res_buf #(
    .PIPE_OUT (PIPE_OUT),
    .CNT_W    (CNT_W)
  ) u_res_buf (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (prod_vld & prod_last),
    .in_res    (sum),
    .in_cnt    (cnt_inc),
    .res_o     (res_o),
    .res_cnt_o (res_cnt_o),
    .res_vld_o (res_vld_o),
    .res_rdy_i (res_rdy_i),
    .ovf_o     (ovf_o)
  );

endmodule

// File: tb/tb_pe_mac_tile.sv
// Self-checking bench: two PEs (PIPE_OUT=0 and PIPE_OUT=1) share stimulus; results are
// scoreboarded per instance, corner cases use hand-written sequences.
module tb_pe_mac_tile;

  logic        clk;
  logic        rst;
  logic [31:0] top_i, left_i;
  logic        top_vld_i, left_vld_i, left_last_i;
  logic        res_rdy_i;

  logic [31:0] bottom0, right0, res0, bottom1, right1, res1;
  logic        bvld0, rvld0, rlast0, vld0, ovf0;
  logic        bvld1, rvld1, rlast1, vld1, ovf1;
  logic [15:0] cnt0, cnt1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [15:0] cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  typedef struct {
    logic [31:0] top;
    logic        tv;
    logic [31:0] left;
    logic        lv;
    logic        last;
    logic        push;
    logic [31:0] res;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[17];

  logic [31:0] exp_bot, exp_right;
  logic        exp_bvld, exp_rvld, exp_rlast;

  pe_mac_tile #(.PIPE_OUT(0), .ZERO_SKIP(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst),
    .top_i(top_i), .top_vld_i(top_vld_i),
    .left_i(left_i), .left_vld_i(left_vld_i), .left_last_i(left_last_i),
    .bottom_o(bottom0), .bottom_vld_o(bvld0),
    .right_o(right0), .right_vld_o(rvld0), .right_last_o(rlast0),
    .res_o(res0), .res_cnt_o(cnt0), .res_vld_o(vld0),
    .res_rdy_i(res_rdy_i), .ovf_o(ovf0)
  );

  pe_mac_tile #(.PIPE_OUT(1), .ZERO_SKIP(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst),
    .top_i(top_i), .top_vld_i(top_vld_i),
    .left_i(left_i), .left_vld_i(left_vld_i), .left_last_i(left_last_i),
    .bottom_o(bottom1), .bottom_vld_o(bvld1),
    .right_o(right1), .right_vld_o(rvld1), .right_last_o(rlast1),
    .res_o(res1), .res_cnt_o(cnt1), .res_vld_o(vld1),
    .res_rdy_i(res_rdy_i), .ovf_o(ovf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected forwarding registers, sampled on the same edge as the DUT inputs.
  always @(posedge clk) begin
    exp_bot   <= rst ? 32'h0 : top_i;
    exp_bvld  <= rst ? 1'b0 : top_vld_i;
    exp_right <= rst ? 32'h0 : left_i;
    exp_rvld  <= rst ? 1'b0 : left_vld_i;
    exp_rlast <= rst ? 1'b0 : left_last_i;
  end

  always @(negedge clk) begin
    exp_t e;
    check("bottom0", bottom0, exp_bot);
    check("right0", right0, exp_right);
    check("fwd_ctl0", {29'd0, bvld0, rvld0, rlast0}, {29'd0, exp_bvld, exp_rvld, exp_rlast});
    check("bottom1", bottom1, exp_bot);
    check("fwd_ctl1", {29'd0, bvld1, rvld1, rlast1}, {29'd0, exp_bvld, exp_rvld, exp_rlast});
    if (vld0 && res_rdy_i) begin
      if (q0.size() == 0) check("unexpected_res0", res0, 32'hDEAD_0000);
      else begin
        e = q0.pop_front();
        check("res0", res0, e.res);
        check("cnt0", {16'd0, cnt0}, {16'd0, e.cnt});
      end
    end
    if (vld1 && res_rdy_i) begin
      if (q1.size() == 0) check("unexpected_res1", res1, 32'hDEAD_0001);
      else begin
        e = q1.pop_front();
        check("res1", res1, e.res);
        check("cnt1", {16'd0, cnt1}, {16'd0, e.cnt});
      end
    end
  end

  task automatic beat(input logic [31:0] t, input logic tv, input logic [31:0] l,
                      input logic lv, input logic last);
    @(posedge clk);
    #1;
    top_i       = t;
    top_vld_i   = tv;
    left_i      = l;
    left_vld_i  = lv;
    left_last_i = last;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic push_both(input logic [31:0] r, input logic [15:0] c);
    q0.push_back('{res: r, cnt: c});
    q1.push_back('{res: r, cnt: c});
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, q0.size() + q1.size(), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_res0"}, res0, 32'h0);
    check({name, "_res1"}, res1, 32'h0);
    check({name, "_ctl0"}, {14'd0, cnt0, vld0, ovf0}, 32'h0);
    check({name, "_ctl1"}, {14'd0, cnt1, vld1, ovf1}, 32'h0);
    check({name, "_fwd"}, bottom0 | right0 | bottom1 | right1, 32'h0);
  endtask

  initial begin
    //           top           tv    left          lv    last  push  res           cnt
    vecs[0]  = '{32'h40000000, 1'b1, 32'h3F800000, 1'b1, 1'b0, 1'b0, 32'h0,        16'd0};
    vecs[1]  = '{32'h40000000, 1'b1, 32'h40000000, 1'b1, 1'b0, 1'b0, 32'h0,        16'd0};
    vecs[2]  = '{32'h40000000, 1'b1, 32'h40400000, 1'b1, 1'b1, 1'b1, 32'h41400000, 16'd3};
    vecs[3]  = '{32'h40000000, 1'b1, 32'h40400000, 1'b1, 1'b0, 1'b0, 32'h0,        16'd0};
    vecs[4]  = '{32'hC0000000, 1'b1, 32'h40400000, 1'b1, 1'b1, 1'b1, 32'h00000000, 16'd2};
    vecs[5]  = '{32'h3F800000, 1'b1, 32'h40800000, 1'b1, 1'b1, 1'b1, 32'h40800000, 16'd1};
    vecs[6]  = '{32'h40000000, 1'b1, 32'h3F800000, 1'b1, 1'b0, 1'b0, 32'h0,        16'd0};
    vecs[7]  = '{32'h40400000, 1'b0, 32'h40400000, 1'b1, 1'b0, 1'b0, 32'h0,        16'd0};
    vecs[8]  = '{32'h80000000, 1'b1, 32'h40400000, 1'b1, 1'b0, 1'b0, 32'h0,        16'd0};
    vecs[9]  = '{32'h40A00000, 1'b0, 32'h40000000, 1'b1, 1'b1, 1'b0, 32'h0,        16'd0};
    vecs[10] = '{32'h3F800000, 1'b1, 32'h40800000, 1'b1, 1'b1, 1'b1, 32'h40C00000, 16'd3};
    vecs[11] = '{32'h3F800000, 1'b1, 32'h80000000, 1'b1, 1'b0, 1'b0, 32'h0,        16'd0};
    vecs[12] = '{32'h40000000, 1'b1, 32'h40000000, 1'b1, 1'b1, 1'b1, 32'h40800000, 16'd2};
    vecs[13] = '{32'h3FC00000, 1'b1, 32'h3FC00000, 1'b1, 1'b1, 1'b1, 32'h40100000, 16'd1};
    vecs[14] = '{32'h40800000, 1'b1, 32'h3F800000, 1'b1, 1'b0, 1'b0, 32'h0,        16'd0};
    vecs[15] = '{32'hBF800000, 1'b1, 32'h3F800000, 1'b1, 1'b1, 1'b1, 32'h40400000, 16'd2};
    vecs[16] = '{32'h00000000, 1'b0, 32'h3F800000, 1'b1, 1'b1, 1'b0, 32'h0,        16'd0};

    rst = 1'b1;
    top_i = 32'h0; top_vld_i = 1'b0; left_i = 32'h0; left_vld_i = 1'b0; left_last_i = 1'b0;
    res_rdy_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    #1 rst = 1'b0;

    // Table: dot product, cancellation + back-to-back tile, valid gaps, signed zeros, subtraction.
    for (int i = 0; i < 17; i++) begin
      beat(vecs[i].top, vecs[i].tv, vecs[i].left, vecs[i].lv, vecs[i].last);
      if (vecs[i].push) push_both(vecs[i].res, vecs[i].cnt);
    end
    idle(1);
    wait_drain("drain_table");

    // Result latency: valid after E2 without output register, after E3 with it.
    beat(32'h40000000, 1'b1, 32'h40000000, 1'b1, 1'b1);
    push_both(32'h40800000, 16'd1);
    beat(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("lat_e0", {30'd0, vld0, vld1}, 32'd0);
    @(negedge clk);
    check("lat_e1", {30'd0, vld0, vld1}, 32'd0);
    @(negedge clk);
    check("lat_e2", {30'd0, vld0, vld1}, 32'd2);
    @(negedge clk);
    check("lat_e3", {30'd0, vld0, vld1}, 32'd1);
    wait_drain("drain_latency");

    // Simultaneous accept + load: buffer FULL, ready rises in the cycle the next result lands.
    res_rdy_i = 1'b0;
    beat(32'h3F800000, 1'b1, 32'h40400000, 1'b1, 1'b1);
    push_both(32'h40400000, 16'd1);
    idle(4);
    @(negedge clk);
    check("simul_held", res0, 32'h40400000);
    beat(32'h3F800000, 1'b1, 32'h40A00000, 1'b1, 1'b1);
    push_both(32'h40A00000, 16'd1);
    idle(2);
    res_rdy_i = 1'b1;
    idle(1);
    @(negedge clk);
    check("simul_next", {31'd0, vld0}, 32'd1);
    wait_drain("drain_simul");
    idle(2);
    check("simul_ovf", {30'd0, ovf0, ovf1}, 32'd0);

    // Backpressure: PIPE_OUT=0 holds one result, PIPE_OUT=1 holds two before overflowing.
    res_rdy_i = 1'b0;
    beat(32'h3F800000, 1'b1, 32'h3F800000, 1'b1, 1'b1);
    push_both(32'h3F800000, 16'd1);
    beat(32'h40000000, 1'b1, 32'h3F800000, 1'b1, 1'b1);
    q1.push_back('{res: 32'h40000000, cnt: 16'd1});
    idle(4);
    @(negedge clk);
    check("bp_res0", res0, 32'h3F800000);
    check("bp_res1", res1, 32'h3F800000);
    check("bp_ovf_a", {29'd0, vld0, ovf0, ovf1}, 32'd6);
    idle(2);
    @(negedge clk);
    check("bp_stable0", {res0[31:16], cnt0}, {16'h3F80, 16'd1});
    beat(32'h40400000, 1'b1, 32'h3F800000, 1'b1, 1'b1);
    idle(4);
    @(negedge clk);
    check("bp_ovf_b", {30'd0, ovf0, ovf1}, 32'd3);
    check("bp_stable1", res1, 32'h3F800000);
    res_rdy_i = 1'b1;
    wait_drain("drain_bp");
    idle(2);
    @(negedge clk);
    check("bp_after", {28'd0, vld0, vld1, ovf0, ovf1}, 32'd3);

    // Reset mid-tile: partial sum discarded, next 1-MAC tile starts clean.
    beat(32'h3F800000, 1'b1, 32'h3F800000, 1'b1, 1'b0);
    beat(32'h3F800000, 1'b1, 32'h3F800000, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    top_i = 32'h0; top_vld_i = 1'b0; left_i = 32'h0; left_vld_i = 1'b0; left_last_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    beat(32'h3F000000, 1'b1, 32'h40800000, 1'b1, 1'b1);
    push_both(32'h40000000, 16'd1);
    idle(1);
    wait_drain("drain_rst");
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
